// File: rtl/ultra_pkg.sv
// Shared types and constants for the ultra CPU bus memory side.
// The opcode constants are also used by the CPU core.
package ultra_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    localparam int MIR3_DEF = 6;
    localparam int MIR4_DEF = 8;
    localparam int MIR5_DEF = 10;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_JZ    = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

endpackage

// File: rtl/ultra_byte_ram.sv
// Single-port byte array: synchronous write, registered read.
// Read data is the pre-write contents of the addressed byte.
module ultra_byte_ram
    import ultra_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BYTE_W-1:0] wdata,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ultra_mem_responder.sv
// Byte-serial 16-bit big-endian word responder for the ultra CPU bus,
// with a byte loader port and shadow mirrors of three mapped words.
module ultra_mem_responder
    import ultra_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int MIR3_ADDR = MIR3_DEF,
    parameter int MIR4_ADDR = MIR4_DEF,
    parameter int MIR5_ADDR = MIR5_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [BYTE_W-1:0] load_byte,
    output logic [WORD_W-1:0] m3,
    output logic [WORD_W-1:0] m4,
    output logic [WORD_W-1:0] m5
);

    localparam logic [ADDR_W-1:0] M3_HI = ADDR_W'(MIR3_ADDR);
    localparam logic [ADDR_W-1:0] M3_LO = ADDR_W'(MIR3_ADDR + 1);
    localparam logic [ADDR_W-1:0] M4_HI = ADDR_W'(MIR4_ADDR);
    localparam logic [ADDR_W-1:0] M4_LO = ADDR_W'(MIR4_ADDR + 1);
    localparam logic [ADDR_W-1:0] M5_HI = ADDR_W'(MIR5_ADDR);
    localparam logic [ADDR_W-1:0] M5_LO = ADDR_W'(MIR5_ADDR + 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   a_q;
    logic [ADDR_W-1:0]   a_inc;
    logic                wr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [BYTE_W-1:0]   rdata_hi;
    logic                accept;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [BYTE_W-1:0]   ram_wdata;
    logic [BYTE_W-1:0]   ram_rdata;

    assign a_inc  = a_q + ADDR_W'(1);
    assign accept = (state == IDLE) && !load_en && req_valid;

    // Reads issue each byte address one cycle early to hide the registered RAM read.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = a_q;
        ram_wdata  = wdata_q[15:8];
        case (state)
            IDLE: begin
                req_ready = !load_en;
                if (load_en) begin
                    ram_we    = 1'b1;
                    ram_addr  = load_addr;
                    ram_wdata = load_byte;
                end else begin
                    ram_addr = req_addr;
                    if (req_valid) begin
                        state_nxt = HI;
                    end
                end
            end
            HI: begin
                ram_we    = wr_q;
                ram_addr  = wr_q ? a_q : a_inc;
                state_nxt = LO;
            end
            LO: begin
                ram_we    = wr_q;
                ram_addr  = a_inc;
                ram_wdata = wdata_q[7:0];
                state_nxt = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    ultra_byte_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            resp_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == LO && !wr_q) begin
                resp_rdata <= {rdata_hi, ram_rdata};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            a_q     <= req_addr;
            wr_q    <= req_write;
            wdata_q <= req_wdata;
        end
        if (state == HI && !wr_q) begin
            rdata_hi <= ram_rdata;
        end
    end

    // Mirrors snoop the single RAM write port, so loader and FSM writes are both seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m3 <= '0;
            m4 <= '0;
            m5 <= '0;
        end else if (ram_we) begin
            if (ram_addr == M3_HI) m3[15:8] <= ram_wdata;
            if (ram_addr == M3_LO) m3[7:0]  <= ram_wdata;
            if (ram_addr == M4_HI) m4[15:8] <= ram_wdata;
            if (ram_addr == M4_LO) m4[7:0]  <= ram_wdata;
            if (ram_addr == M5_HI) m5[15:8] <= ram_wdata;
            if (ram_addr == M5_LO) m5[7:0]  <= ram_wdata;
        end
    end

endmodule

// File: tb/tb_ultra_mem_responder.sv
// Randomized self-checking bench for ultra_mem_responder against a
// byte-array reference model with word-level mirror tracking.
module tb_ultra_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        load_en = 1'b0;
    logic [9:0]  load_addr = '0;
    logic [7:0]  load_byte = '0;
    logic [15:0] m3, m4, m5;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mdl_mem [1024];
    logic [15:0] mdl_mir [3];

    ultra_mem_responder dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_byte  (load_byte),
        .m3         (m3),
        .m4         (m4),
        .m5         (m5)
    );

    always #5 clock = ~clock;

    function automatic void mdl_byte(input int addr, input logic [7:0] b);
        int a;
        a = addr % 1024;
        mdl_mem[a] = b;
        for (int k = 0; k < 3; k++) begin
            if (a == 6 + 2 * k) mdl_mir[k][15:8] = b;
            if (a == 7 + 2 * k) mdl_mir[k][7:0] = b;
        end
    endfunction

    function automatic void mdl_write(input int addr, input logic [15:0] w);
        mdl_byte(addr, w[15:8]);
        mdl_byte(addr + 1, w[7:0]);
    endfunction

    function automatic logic [15:0] mdl_read(input int addr);
        return {mdl_mem[addr % 1024], mdl_mem[(addr + 1) % 1024]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input int addr, input logic [7:0] b);
        load_en   = 1'b1;
        load_addr = 10'(addr);
        load_byte = b;
        tick();
        load_en = 1'b0;
        mdl_byte(addr, b);
    endtask

    // Issue one request, wait for its accept and response; leaves the DUT back in IDLE.
    task automatic req_word(input logic wr, input int addr, input logic [15:0] wd,
                            output int lat, output logic one_wide, output logic [15:0] rd);
        int wait_cnt;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = 10'(addr);
        req_wdata = wd;
        wait_cnt  = 0;
        while (!req_ready && wait_cnt < 8) begin
            tick();
            wait_cnt++;
        end
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 8) begin
            tick();
            lat++;
        end
        rd = resp_rdata;
        tick();
        one_wide = !resp_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%h want=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%h want=0", resp_valid); end
        checks++; if (resp_rdata !== 16'h0) begin errors++; $display("FAIL reset_resp_rdata got=%h want=0000", resp_rdata); end
        checks++; if ({m3, m4, m5} !== 48'h0) begin errors++; $display("FAIL reset_mirrors got=%h %h %h want=0", m3, m4, m5); end
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) mdl_mir[k] = 16'h0;
        tick();
    endtask

    task automatic test_preload();
        for (int i = 0; i < 1024; i++) do_load(i, 8'($urandom));
        checks++; if (m3 !== mdl_mir[0]) begin errors++; $display("FAIL preload_m3 got=%h want=%h", m3, mdl_mir[0]); end
        checks++; if (m4 !== mdl_mir[1]) begin errors++; $display("FAIL preload_m4 got=%h want=%h", m4, mdl_mir[1]); end
        checks++; if (m5 !== mdl_mir[2]) begin errors++; $display("FAIL preload_m5 got=%h want=%h", m5, mdl_mir[2]); end
    endtask

    task automatic test_load_read();
        int lat; logic one; logic [15:0] rd;
        do_load(20, 8'h40);
        do_load(21, 8'h06);
        req_word(1'b0, 20, 16'h0, lat, one, rd);
        checks++; if (rd !== 16'h4006) begin errors++; $display("FAIL load_read_data got=%h want=4006", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_read_latency got=%0d want=2", lat); end
        checks++; if (one !== 1'b1) begin errors++; $display("FAIL load_read_pulse_width got=%h want=1", one); end
    endtask

    task automatic test_write_mirror();
        int lat; logic one; logic [15:0] rd;
        req_word(1'b1, 6, 16'h1234, lat, one, rd);
        mdl_write(6, 16'h1234);
        checks++; if (m3 !== 16'h1234) begin errors++; $display("FAIL write_m3 got=%h want=1234", m3); end
        checks++; if (lat !== 2 || one !== 1'b1) begin errors++; $display("FAIL write_resp_timing got=%0d/%h want=2/1", lat, one); end
        req_word(1'b0, 6, 16'h0, lat, one, rd);
        checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL write_readback got=%h want=1234", rd); end
        req_word(1'b1, 7, 16'h5AA5, lat, one, rd);
        mdl_write(7, 16'h5AA5);
        checks++; if (m3 !== mdl_mir[0] || m4 !== mdl_mir[1]) begin errors++; $display("FAIL unaligned_mirrors got=%h %h want=%h %h", m3, m4, mdl_mir[0], mdl_mir[1]); end
    endtask

    task automatic test_wrap();
        int lat; logic one; logic [15:0] rd;
        req_word(1'b1, 1023, 16'hABCD, lat, one, rd);
        mdl_write(1023, 16'hABCD);
        req_word(1'b0, 1023, 16'h0, lat, one, rd);
        checks++; if (rd !== 16'hABCD) begin errors++; $display("FAIL wrap_read got=%h want=abcd", rd); end
        req_word(1'b0, 0, 16'h0, lat, one, rd);
        checks++; if (rd !== mdl_read(0)) begin errors++; $display("FAIL wrap_byte0 got=%h want=%h", rd, mdl_read(0)); end
    endtask

    task automatic test_load_priority();
        int lat; logic [7:0] b; logic [15:0] exp;
        b = 8'($urandom);
        load_en = 1'b1; load_addr = 10'd100; load_byte = b;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd100;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL prio_req_ready_low got=%h want=0", req_ready); end
        tick();
        load_en = 1'b0;
        mdl_byte(100, b);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL prio_req_ready_high got=%h want=1", req_ready); end
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 8) begin tick(); lat++; end
        exp = mdl_read(100);
        checks++; if (lat !== 2) begin errors++; $display("FAIL prio_accept_latency got=%0d want=2", lat); end
        checks++; if (resp_rdata !== exp) begin errors++; $display("FAIL prio_read_data got=%h want=%h", resp_rdata, exp); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, pulses; logic one; logic [15:0] rd;
        do_load(8, 8'h11);
        do_load(9, 8'h55);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd8; req_wdata = 16'hBEEF;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready got=%h want=1", req_ready); end
        checks++; if (m4 !== 16'h0) begin errors++; $display("FAIL midrst_m4 got=%h want=0000", m4); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid) pulses++;
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) pulses++;
            tick();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_resp_pulses got=%0d want=0", pulses); end
        mdl_mem[8] = 8'hBE;
        for (int k = 0; k < 3; k++) mdl_mir[k] = 16'h0;
        req_word(1'b0, 8, 16'h0, lat, one, rd);
        checks++; if (rd !== 16'hBE55) begin errors++; $display("FAIL midrst_partial_write got=%h want=be55", rd); end
        checks++; if ({m3, m4, m5} !== 48'h0) begin errors++; $display("FAIL midrst_mirrors got=%h %h %h want=0", m3, m4, m5); end
    endtask

    task automatic test_back_to_back();
        int acc[$]; int rsp[$]; logic [15:0] dat[$];
        logic rdy;
        int a0, a1, r0, r1;
        logic [15:0] d0, d1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd200;
        for (int i = 0; i < 8; i++) begin
            rdy = req_ready;
            tick();
            if (rdy) acc.push_back(i);
            if (resp_valid) begin rsp.push_back(i); dat.push_back(resp_rdata); end
            if (acc.size() == 1) req_addr = 10'd301;
        end
        req_valid = 1'b0;
        a0 = acc.size() > 0 ? acc[0] : -1;
        a1 = acc.size() > 1 ? acc[1] : -1;
        r0 = rsp.size() > 0 ? rsp[0] : -1;
        r1 = rsp.size() > 1 ? rsp[1] : -1;
        d0 = dat.size() > 0 ? dat[0] : 16'hxxxx;
        d1 = dat.size() > 1 ? dat[1] : 16'hxxxx;
        checks++; if (acc.size() !== 2 || a0 !== 0 || a1 !== 4) begin errors++; $display("FAIL b2b_accepts got=%0d@%0d,%0d want=2@0,4", acc.size(), a0, a1); end
        checks++; if (rsp.size() !== 2 || r0 !== 2 || r1 !== 6) begin errors++; $display("FAIL b2b_resps got=%0d@%0d,%0d want=2@2,6", rsp.size(), r0, r1); end
        checks++; if (d0 !== mdl_read(200) || d1 !== mdl_read(301)) begin errors++; $display("FAIL b2b_data got=%h,%h want=%h,%h", d0, d1, mdl_read(200), mdl_read(301)); end
        tick();
    endtask

    task automatic test_random();
        int lat, addr; logic one, wr; logic [15:0] rd, wd, exp;
        for (int n = 0; n < 60; n++) begin
            addr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) begin
                do_load(addr, 8'($urandom));
            end else begin
                wr = 1'($urandom_range(0, 1));
                wd = 16'($urandom);
                exp = mdl_read(addr);
                req_word(wr, addr, wd, lat, one, rd);
                if (wr) mdl_write(addr, wd);
                checks++; if (lat !== 2 || one !== 1'b1) begin errors++; $display("FAIL rand_timing n=%0d got=%0d/%h want=2/1", n, lat, one); end
                if (!wr) begin
                    checks++; if (rd !== exp) begin errors++; $display("FAIL rand_read n=%0d addr=%0d got=%h want=%h", n, addr, rd, exp); end
                end
            end
            checks++; if (m3 !== mdl_mir[0] || m4 !== mdl_mir[1] || m5 !== mdl_mir[2]) begin
                errors++; $display("FAIL rand_mirrors n=%0d got=%h %h %h want=%h %h %h", n, m3, m4, m5, mdl_mir[0], mdl_mir[1], mdl_mir[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_load_read();
        test_write_mirror();
        test_wrap();
        test_load_priority();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ultra_mem_responder.md
Name: ultra_mem_responder

Overview:
- Memory-side responder for the ultra CPU bus: serves 16-bit word read/write requests from a 1024 x 8-bit byte array.
- Word layout is big-endian: byte at addr holds word[15:8]; byte at addr+1 holds word[7:0].
- Byte-serial access, one byte per cycle. Includes a byte-wide loader port for program/data preload.
- Provides memory-mapped output mirrors M3/M4/M5 (words at byte addresses 6, 8, 10).

Parameters:
- ADDR_W, 10, byte address width.
- DEPTH, 1024, number of bytes; equals 2**ADDR_W.
- MIR3_ADDR, 6, byte address of mirror m3 (high byte; low byte at +1).
- MIR4_ADDR, 8, byte address of mirror m4.
- MIR5_ADDR, 10, byte address of mirror m5.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_write  in  1  1 = write word, 0 = read word.
- req_addr  in  ADDR_W  byte address of the high byte.
- req_wdata  in  16  write data.
- req_ready  out  1  request accepted on an edge where req_valid & req_ready.
- resp_valid  out  1  one-cycle pulse: read data valid, or write complete.
- resp_rdata  out  16  read word; holds its value until the next read completes.
- load_en  in  1  loader byte write strobe.
- load_addr  in  ADDR_W  loader byte address.
- load_byte  in  8  loader data.
- m3, m4, m5  out  16 each  mirror words.

Behaviour:
- Reset (async, active-high) values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, m3=m4=m5=0. Memory array is not cleared.
- FSM states: IDLE -> HI -> LO -> DONE -> IDLE.
- IDLE:
  - req_ready = ~load_en.
  - load_en high: write load_byte to MEM[load_addr]; stay in IDLE. Loader has priority over a simultaneous request; that request is not accepted.
  - Otherwise, req_valid high: latch addr, write flag and wdata; go to HI.
- HI:
  - Write: MEM[a] <= wdata[15:8].
  - Read: rdata_hi <= MEM[a].
  - req_ready=0; load_en ignored.
- LO:
  - Access byte a+1, computed mod DEPTH (a=1023 wraps to byte 0).
  - Write: MEM[a+1] <= wdata[7:0].
  - Read: resp_rdata <= {rdata_hi, MEM[a+1]}.
- DONE: resp_valid=1 for exactly this cycle; req_ready=0; next state IDLE.
- Timing:
  - Accept at edge k -> resp_valid high between edges k+2 and k+3.
  - Earliest next accept is edge k+4, giving 1 word per 4 cycles.
- Odd addresses are legal; there is no alignment check.
- Mirrors:
  - Shadow registers, updated on the same edge as any byte write (FSM or loader) to a mirrored byte.
  - High byte at MIRx_ADDR, low byte at MIRx_ADDR+1.
  - Unaligned writes (e.g. a=7) update the low byte of m3 and the high byte of m4.
  - Mirrors reflect only writes since reset.
- Reset mid-operation:
  - FSM returns to IDLE and any pending response is dropped.
  - Bytes already written stay written, so a partial write (high byte only) is possible and legal.
  - Mirrors clear to 0.
- Reads of never-written bytes return X in simulation; the bench preloads via the loader port.

Decomposition:
- Package ultra_pkg holds:
  - state typedef (IDLE/HI/LO/DONE);
  - WORD_W=16, BYTE_W=8;
  - mirror address constants;
  - CPU opcode constants (shared with the CPU).
- One sub-module, ultra_byte_ram: 1024x8, single port, synchronous write, read registered on the edge. The loader and the FSM are muxed onto its port.
- Mirror update logic stays in the top module.

Test Plan:
- Load 0x40,0x06 at bytes 20,21; read at 20 -> resp_rdata=0x4006; resp_valid at the 3rd edge after accept, one cycle wide.
- Write 0x1234 at addr 6 -> MEM[6]=0x12, MEM[7]=0x34; m3=0x1234 after the LO edge; read-back returns 0x1234.
- Write 0xABCD at addr 1023 -> MEM[1023]=0xAB, MEM[0]=0xCD; read at 1023 returns 0xABCD.
- load_en and req_valid asserted together in IDLE -> loader byte written, req_ready=0, request accepted on the following cycle.
- Write 0xBEEF at addr 8; assert reset one cycle after accept -> MEM[8]=0xBE, MEM[9] unchanged, no resp_valid, m4=0, req_ready=1.
- Two back-to-back reads with req_valid held -> accepts at edges k and k+4; two resp_valid pulses 4 cycles apart.
